cyclic74_encoder: RTL and testbench

- Serial systematic (7,4) cyclic encoder. It is the stage directly upstream of the team's serial cyclic decoder, which consumes the 7-bit codeword this block produces.
- Takes a 4-bit message over a valid/ready handshake. Divides m(x)·x^3 by g(x) with a 3-bit LFSR, one message bit per clock, MSB first.
- Presents codeword c[6:0], with c[6] as the highest-order term, over a valid/ready handshake.
- Optional error injection gives the decoder testbench a single-bit-error source.

---
 rtl/cyc74_pkg.sv | 19 +
 rtl/cyc74_lfsr_div.sv | 44 ++++
 rtl/cyclic74_encoder.sv | 118 +++++++++++
 tb/tb_cyclic74_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cyc74_pkg.sv
// Shared constants and types for the serial (7,4) cyclic encoder/decoder pair.
package cyc74_pkg;

    localparam int             CYC74_N         = 7;
    localparam int             CYC74_K         = 4;
    localparam int             CYC74_R         = 3;
    localparam logic [3:0]     CYC74_G_DEFAULT = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cyc74_state_e;

    typedef logic [CYC74_N-1:0] cyc74_cw_t;
    typedef logic [CYC74_K-1:0] cyc74_msg_t;
    typedef logic [CYC74_R-1:0] cyc74_rem_t;

endpackage

// File: rtl/cyc74_lfsr_div.sv
// 3-bit Galois LFSR divider: accumulates din(x) * x^3 mod g(x), MSB first.
// Also used by the decoder's syndrome stage.
module cyc74_lfsr_div
    import cyc74_pkg::*;
#(
    parameter logic [3:0] GEN_POLY = CYC74_G_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       din,
    output cyc74_rem_t rem
);

    cyc74_rem_t rem_q;
    cyc74_rem_t rem_d;
    logic       fb;

    // Next remainder: clear has priority, otherwise one division step per shift.
    always_comb begin
        rem_d = rem_q;
        fb    = din ^ rem_q[2];
        if (clr) begin
            rem_d = '0;
        end else if (shift_en) begin
            rem_d[2] = rem_q[1] ^ (GEN_POLY[2] & fb);
            rem_d[1] = rem_q[0] ^ (GEN_POLY[1] & fb);
            rem_d[0] = fb;
        end
    end

    // Remainder register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/cyclic74_encoder.sv
// Serial systematic (7,4) cyclic encoder with valid/ready on both sides.
// Codeword c = {msg, msg(x)*x^3 mod g(x)}; one message bit per clock.
// Optional single-bit error injection is built when CYC74_ERR_INJ_EN is defined.
module cyclic74_encoder
    import cyc74_pkg::*;
#(
    parameter logic [3:0] GEN_POLY = CYC74_G_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] msg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] c,
    output logic       busy
`ifdef CYC74_ERR_INJ_EN
    ,
    input  logic       err_en,
    input  logic [2:0] err_pos
`endif
);

    cyc74_state_e state_q, state_d;
    cyc74_msg_t   msg_q,   msg_d;
    logic [1:0]   cnt_q,   cnt_d;
    cyc74_rem_t   rem;
    logic         accept;
    logic         last_shift;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_shift = (state_q == SHIFT) && (cnt_q == 2'd0);

    cyc74_lfsr_div #(
        .GEN_POLY (GEN_POLY)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .shift_en (state_q == SHIFT),
        .din      (msg_q[cnt_q]),
        .rem      (rem)
    );

    // State register plus message/counter holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept, four shift steps, then hold until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = SHIFT;
            SHIFT:   if (cnt_q == 2'd0) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Message capture on accept; bit counter walks MSB to LSB during SHIFT.
    always_comb begin
        msg_d = msg_q;
        cnt_d = cnt_q;
        if (accept) begin
            msg_d = msg;
            cnt_d = 2'd3;
        end else if ((state_q == SHIFT) && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

`ifdef CYC74_ERR_INJ_EN
    cyc74_cw_t flip_q, flip_d;

    // Error mask is captured on the edge entering DONE and held through DONE.
    always_comb begin
        flip_d = flip_q;
        if (last_shift) begin
            flip_d = (err_en && (err_pos != 3'd7)) ? (cyc74_cw_t'(1) << err_pos) : '0;
        end
    end

    // Error mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_q <= '0;
        end else begin
            flip_q <= flip_d;
        end
    end
`endif

    // Outputs decode registered state only; c is zero outside DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        c         = '0;
        if (state_q == DONE) begin
`ifdef CYC74_ERR_INJ_EN
            c = {msg_q, rem} ^ flip_q;
`else
            c = {msg_q, rem};
`endif
        end
    end

endmodule

// File: tb/tb_cyclic74_encoder.sv
// Bench for cyclic74_encoder: constant vectors, scoreboard against a
// polynomial long-division model, backpressure, streaming and reset corners.
module tb_cyclic74_encoder;

    localparam logic [3:0] GEN = 4'b1011;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] msg;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] c;
    logic       busy;
`ifdef CYC74_ERR_INJ_EN
    logic       err_en;
    logic [2:0] err_pos;
`endif

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int cyc    = 0;
    logic [6:0] sb_q[$];

    typedef struct {
        logic [3:0] m;
        logic [6:0] cw;
    } vec_t;
    vec_t tbl[5];

    cyclic74_encoder #(.GEN_POLY(GEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .msg       (msg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
`ifdef CYC74_ERR_INJ_EN
        ,
        .err_en    (err_en),
        .err_pos   (err_pos)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: long division of m(x)*x^3 by g(x).
    function automatic logic [6:0] ref_cw(input logic [3:0] m);
        logic [6:0] d;
        d = {m, 3'b000};
        for (int i = 6; i >= 3; i--) begin
            if (d[i]) d = d ^ (7'(GEN) << (i - 3));
        end
        return {m, d[2:0]};
    endfunction

    function automatic logic [6:0] expect_cw(input logic [3:0] m);
        logic [6:0] e;
        e = ref_cw(m);
`ifdef CYC74_ERR_INJ_EN
        if (err_en && err_pos != 3'd7) e[err_pos] = ~e[err_pos];
`endif
        return e;
    endfunction

    // Scoreboard: push on accept, pop on output handshake (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) sb_q.push_back(expect_cw(msg));
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", {25'd0, c}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_codeword", {25'd0, c}, {25'd0, sb_q.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a message, wait for acceptance and then for out_valid; return c.
    task automatic send(input logic [3:0] m, output logic [6:0] got);
        int n;
        msg      = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        got = c;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_c"},         {25'd0, c},         32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] got;
        logic [6:0] held;
        int         exp_outs;
        int         last_acc;
        int         n;

        tbl[0] = '{4'b0001, 7'b0001011};
        tbl[1] = '{4'b1000, 7'b1000101};
        tbl[2] = '{4'b1010, 7'b1010011};
        tbl[3] = '{4'b1111, 7'b1111111};
        tbl[4] = '{4'b0000, 7'b0000000};

        rst       = 1'b1;
        in_valid  = 1'b0;
        msg       = 4'd0;
        out_ready = 1'b1;
`ifdef CYC74_ERR_INJ_EN
        err_en    = 1'b0;
        err_pos   = 3'd7;
`endif
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();

        // Latency: accept at edge E, out_valid after E+4.
        msg      = 4'b0001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("latency_early", {31'd0, out_valid}, 32'd0);
            check("latency_busy",  {31'd0, busy},      32'd1);
        end
        step();
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_c",     {25'd0, c},         32'b0001011);
        exp_outs = 1;
        step();

        // Constant vectors.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].m, got);
            check($sformatf("vec_%0d", i), {25'd0, got}, {25'd0, tbl[i].cw});
            exp_outs++;
            step();
        end

        // Exhaustive sweep through the scoreboard.
        for (int m = 0; m < 16; m++) begin
            send(4'(m), got);
            exp_outs++;
            step();
        end

        // Backpressure with input noise during the stall.
        out_ready = 1'b0;
        send(4'b1010, held);
        check("bp_c", {25'd0, held}, 32'b1010011);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            msg      = 4'($urandom_range(0, 15));
            step();
            check("bp_hold_c",     {25'd0, c},         {25'd0, held});
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready},  32'd1);
        exp_outs++;

        // Streaming with both handshakes held high.
        in_valid = 1'b1;
        last_acc = 0;
        for (int m = 0; m < 16; m++) begin
            msg = 4'(m);
            n = 0;
            while (!in_ready && n < 20) begin step(); n++; end
            step();
            if (m > 0) check("stream_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
        end
        in_valid = 1'b0;
        exp_outs += 16;
        for (int k = 0; k < 8; k++) step();

        // Reset on the second shift edge discards the word.
        msg      = 4'b1101;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("midrst");
        for (int k = 0; k < 6; k++) begin
            step();
            check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        send(4'b0110, got);
        check("post_rst_c", {25'd0, got}, {25'd0, ref_cw(4'b0110)});
        exp_outs++;
        step();

`ifdef CYC74_ERR_INJ_EN
        err_en  = 1'b1;
        err_pos = 3'd4;
        send(4'b0001, got);
        check("err_pos4", {25'd0, got}, 32'b0011011);
        exp_outs++;
        step();
        err_pos = 3'd7;
        send(4'b0001, got);
        check("err_pos7", {25'd0, got}, 32'b0001011);
        exp_outs++;
        step();
        err_en = 1'b0;
`endif

        for (int k = 0; k < 4; k++) step();
        check("sb_drained",   32'(sb_q.size()), 32'd0);
        check("output_count", 32'(n_out),       32'(exp_outs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
